// File: rtl/wb_mac_array.sv
// -----------------------------------------------------------------------------
// wb_mac_array
//
// Wishbone-slave multi-channel multiply-accumulate engine. CHANNELS signed
// operand pairs A[i]/B[i] and accumulators ACC[i] sit behind a Wishbone
// register file. A START command sequences one shared, pipelined multiplier
// over all channels. The product stage feeds an accumulate stage one cycle
// later, and DONE is raised (and irq_o, if IE is set) when the run drains.
//
// Register map (byte offsets, only wbs_adr_i[9:2] decoded):
//   0x000        CTRL   W: bit0 START, bit1 CLEAR, bit2 IE, bit3 SAT_BYPASS
//                       R: bit2 IE, bit3 SAT_BYPASS (0 when saturation absent)
//   0x004        STATUS R: bit0 BUSY, bit1 DONE, bit2 OVF; W1C on bit1/bit2
//   0x100 + 4*i  A[i]   DW-bit signed operand, read sign-extended
//   0x180 + 4*i  B[i]   DW-bit signed operand, read sign-extended
//   0x200 + 4*i  ACC[i] ACC_W-bit accumulator, read sign-extended
//
// Optional feature: define WB_MAC_ARRAY_SATURATE_EN to make the accumulate
// saturate instead of wrap; CTRL.SAT_BYPASS then restores wrapping at runtime.
//
// Ports:
//   wb_clk_i   clock
//   wb_rst_ni  asynchronous active-low reset
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i
//              Wishbone slave request (sel all-zero suppresses the write)
//   wbs_ack_o  one-cycle acknowledge, the cycle after the request
//   wbs_dat_o  read data, valid only while wbs_ack_o is high, else 0
//   irq_o      level interrupt = DONE & IE
// -----------------------------------------------------------------------------
module wb_mac_array #(
  parameter int CHANNELS = 4,
  parameter int DW       = 16,
  parameter int ACC_W    = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = 2 * DW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;       // multiply-stage channel
  logic signed [PW-1:0]      p_q, p_d;           // product register
  logic [IW-1:0]             p_idx_q, p_idx_d;   // channel owning p_q
  logic                      p_vld_q, p_vld_d;   // p_q must be accumulated

  logic signed [DW-1:0]      a_q   [CHANNELS];
  logic signed [DW-1:0]      a_d   [CHANNELS];
  logic signed [DW-1:0]      b_q   [CHANNELS];
  logic signed [DW-1:0]      b_d   [CHANNELS];
  logic signed [ACC_W-1:0]   acc_q [CHANNELS];
  logic signed [ACC_W-1:0]   acc_d [CHANNELS];

  logic                      ie_q, ie_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;
  logic                      ack_q, ack_d;
  logic [31:0]               dat_q, dat_d;
  logic                      irq_q, irq_d;
`ifdef WB_MAC_ARRAY_SATURATE_EN
  logic                      sat_bypass_q, sat_bypass_d;
`endif

  // ---------------------------------------------------------------------------
  // Wishbone decode
  // ---------------------------------------------------------------------------
  logic          req;
  logic          wr_en;
  logic          busy;
  logic [7:0]    word;
  logic [4:0]    ch;
  logic [IW-1:0] ch_idx;
  logic          ch_ok;
  logic          sel_ctrl, sel_status, sel_a, sel_b, sel_acc;

  // A request is taken only while no ack is outstanding, which yields the
  // one-cycle ack and the two-cycle back-to-back cadence.
  assign req        = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr_en      = req & wbs_we_i & (|wbs_sel_i);
  assign busy       = (state_q != S_IDLE);
  assign word       = wbs_adr_i[9:2];
  assign ch         = word[4:0];
  assign ch_idx     = ch[IW-1:0];
  assign ch_ok      = (32'(ch) < CHANNELS);
  assign sel_ctrl   = (word == 8'h00);
  assign sel_status = (word == 8'h01);
  assign sel_a      = (word[7:5] == 3'b010);
  assign sel_b      = (word[7:5] == 3'b011);
  assign sel_acc    = (word[7:5] == 3'b100);

  // Address bits outside [9:2] and unused data bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{wbs_adr_i[31:10], wbs_adr_i[1:0], wbs_dat_i};

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data;

  // NOTE: every signal driven in an always_comb gets a default on entry so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data = '0;
    if (sel_ctrl) begin
`ifdef WB_MAC_ARRAY_SATURATE_EN
      rd_data = {28'b0, sat_bypass_q, ie_q, 2'b00};
`else
      rd_data = {29'b0, ie_q, 2'b00};
`endif
    end else if (sel_status) begin
      rd_data = {29'b0, ovf_q, done_q, busy};
    end else if (ch_ok) begin
      if (sel_a)        rd_data = 32'(a_q[ch_idx]);
      else if (sel_b)   rd_data = 32'(b_q[ch_idx]);
      else if (sel_acc) rd_data = 32'(acc_q[ch_idx]);
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate datapath (stage 2)
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc_cur;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_res;
  logic                    add_ovf;

  always_comb begin
    acc_cur = acc_q[p_idx_q];
    addend  = ACC_W'(p_q);
    sum     = acc_cur + addend;
    // Two's complement overflow: operands agree in sign, result does not.
    add_ovf = (acc_cur[ACC_W-1] == addend[ACC_W-1]) &&
              (sum[ACC_W-1] != acc_cur[ACC_W-1]);
    acc_res = sum;
`ifdef WB_MAC_ARRAY_SATURATE_EN
    if (add_ovf && !sat_bypass_q) begin
      // Overflow direction follows the shared operand sign.
      acc_res = acc_cur[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    p_d     = p_q;
    p_idx_d = p_idx_q;
    p_vld_d = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    ie_d    = ie_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    ack_d   = req;
    dat_d   = (req && !wbs_we_i) ? rd_data : '0;
`ifdef WB_MAC_ARRAY_SATURATE_EN
    sat_bypass_d = sat_bypass_q;
`endif

    // Host writes. IE/SAT_BYPASS and the W1C bits are honoured even while a
    // run is in progress; operands, accumulators and commands are not.
    if (wr_en) begin
      if (sel_ctrl) begin
        ie_d = wbs_dat_i[2];
`ifdef WB_MAC_ARRAY_SATURATE_EN
        sat_bypass_d = wbs_dat_i[3];
`endif
        if (!busy) begin
          // CLEAR lands on the same edge as START; the first accumulate is
          // two edges later, so the run always sees zeroed accumulators.
          if (wbs_dat_i[1]) acc_d = '{default: '0};
          if (wbs_dat_i[0]) begin
            state_d = S_RUN;
            idx_d   = '0;
          end
        end
      end
      if (sel_status) begin
        if (wbs_dat_i[1]) done_d = 1'b0;
        if (wbs_dat_i[2]) ovf_d  = 1'b0;
      end
      if (!busy && ch_ok) begin
        if (sel_a)   a_d[ch_idx]   = wbs_dat_i[DW-1:0];
        if (sel_b)   b_d[ch_idx]   = wbs_dat_i[DW-1:0];
        if (sel_acc) acc_d[ch_idx] = wbs_dat_i[ACC_W-1:0];
      end
    end

    // Multiply stage and sequencing.
    case (state_q)
      S_RUN: begin
        p_d     = PW'(a_q[idx_q]) * PW'(b_q[idx_q]);
        p_idx_d = idx_q;
        p_vld_d = 1'b1;
        if (idx_q == IW'(CHANNELS - 1)) state_d = S_DRAIN;
        else                            idx_d   = idx_q + IW'(1);
      end
      S_DRAIN: begin
        // The last product is accumulated on this same edge.
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: ;
    endcase

    // Accumulate stage; placed after the W1C handling so a hardware set
    // of OVF wins over a simultaneous clear (DONE likewise above).
    if (p_vld_q) begin
      acc_d[p_idx_q] = acc_res;
      if (add_ovf) ovf_d = 1'b1;
    end

    irq_d = done_d & ie_d;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples its _d value from before the edge regardless of order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      p_q     <= '0;
      p_idx_q <= '0;
      p_vld_q <= 1'b0;
      // NOTE: the operand and accumulator arrays are reset because software
      // relies on them reading 0 and an aborted run must leave nothing behind;
      // that keeps them in flops rather than a RAM macro.
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      acc_q   <= '{default: '0};
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
`ifdef WB_MAC_ARRAY_SATURATE_EN
      sat_bypass_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      p_q     <= p_d;
      p_idx_q <= p_idx_d;
      p_vld_q <= p_vld_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
`ifdef WB_MAC_ARRAY_SATURATE_EN
      sat_bypass_q <= sat_bypass_d;
`endif
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_mac_array.sv
// -----------------------------------------------------------------------------
// tb_wb_mac_array
//
// Directed bench for wb_mac_array (CHANNELS=4, DW=16, ACC_W=32). A table of
// register accesses covers decode, sign extension and unmapped space; hand
// written sequences cover run timing, BUSY lockout, DONE set-vs-clear,
// interrupt behaviour and reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_wb_mac_array;

  localparam logic [31:0] R_CTRL   = 32'h000;
  localparam logic [31:0] R_STATUS = 32'h004;
  localparam logic [31:0] R_A      = 32'h100;
  localparam logic [31:0] R_B      = 32'h180;
  localparam logic [31:0] R_ACC    = 32'h200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat_o;
  logic        irq;

  int checks = 0;
  int errors = 0;

  wb_mac_array #(.CHANNELS(4), .DW(16), .ACC_W(32)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat_o),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One Wishbone transfer; returns 1 ns after the edge that raised ack.
  task automatic wb_xfer(input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r, output int lat);
    int n;
    n = 0;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ack && n < 8);
    r   = rdat_o;
    lat = n;
    if (!ack) check("ack_timeout", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int lat;
    wb_xfer(1'b1, 4'hF, a, d, r, lat);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    int lat;
    wb_xfer(1'b0, 4'hF, a, 32'h0, r, lat);
  endtask

  task automatic read_check(input string name, input logic [31:0] a,
                            input logic [31:0] exp);
    logic [31:0] r;
    wb_read(a, r);
    check(name, r, exp);
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [24];

  initial begin
    logic [31:0] r;
    int lat;
    int k;

    vecs[0]  = '{1'b0, 4'hF, R_STATUS,        32'h0,        1'b1, 32'h0};
    vecs[1]  = '{1'b0, 4'hF, R_ACC,           32'h0,        1'b1, 32'h0};
    vecs[2]  = '{1'b0, 4'hF, R_CTRL,          32'h0,        1'b1, 32'h0};
    vecs[3]  = '{1'b1, 4'hF, R_A + 0,         32'd3,        1'b0, 32'h0};
    vecs[4]  = '{1'b1, 4'hF, R_A + 4,         32'hFFFFFFFE, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 4'hF, R_A + 8,         32'd100,      1'b0, 32'h0};
    vecs[6]  = '{1'b1, 4'hF, R_A + 12,        32'h00008000, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 4'hF, R_B + 0,         32'd4,        1'b0, 32'h0};
    vecs[8]  = '{1'b1, 4'hF, R_B + 4,         32'd5,        1'b0, 32'h0};
    vecs[9]  = '{1'b1, 4'hF, R_B + 8,         32'hFFFFFFF9, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 4'hF, R_B + 12,        32'h00008000, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 4'hF, R_A + 4,         32'h0,        1'b1, 32'hFFFFFFFE};
    vecs[12] = '{1'b0, 4'hF, R_B + 12,        32'h0,        1'b1, 32'hFFFF8000};
    vecs[13] = '{1'b0, 4'hF, R_A + 8,         32'h0,        1'b1, 32'h00000064};
    vecs[14] = '{1'b1, 4'hF, R_A + 20,        32'h55,       1'b0, 32'h0};
    vecs[15] = '{1'b0, 4'hF, R_A + 20,        32'h0,        1'b1, 32'h0};
    vecs[16] = '{1'b0, 4'hF, R_A + 16,        32'h0,        1'b1, 32'h0};
    vecs[17] = '{1'b1, 4'hF, R_ACC + 4,       32'h80000001, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 4'hF, R_ACC + 4,       32'h0,        1'b1, 32'h80000001};
    vecs[19] = '{1'b1, 4'hF, R_CTRL,          32'h2,        1'b0, 32'h0};
    vecs[20] = '{1'b0, 4'hF, R_ACC + 4,       32'h0,        1'b1, 32'h0};
    vecs[21] = '{1'b0, 4'hF, 32'h300,         32'h0,        1'b1, 32'h0};
    vecs[22] = '{1'b1, 4'h0, R_A + 0,         32'h77,       1'b0, 32'h0};
    vecs[23] = '{1'b0, 4'hF, 32'h504,         32'h0,        1'b1, 32'hFFFFFFFE};

    // ---------------- reset ----------------
    wait_cycles(3);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", rdat_o, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // First transfer: ack one cycle after strobe, gone the cycle after.
    wb_xfer(1'b0, 4'hF, R_STATUS, 32'h0, r, lat);
    check("ack_latency", 32'(lat), 32'd1);
    check("ack_dat", r, 32'h0);
    wait_cycles(1);
    check("ack_one_cycle", {31'b0, ack}, 32'd0);
    check("dat_idle_zero", rdat_o, 32'h0);

    // ---------------- register table ----------------
    for (int i = 0; i < 24; i++) begin
      wb_xfer(vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d, r, lat);
      if (vecs[i].chk) check($sformatf("vec%0d", i), r, vecs[i].exp);
    end
    read_check("sel0_nowrite", R_A, 32'd3);

    // ---------------- run 1: CLEAR|START ----------------
    wb_write(R_CTRL, 32'h3);                  // commit edge E0
    read_check("run1_busy_e2", R_STATUS, 32'h1);        // edge E0+2
    wait_cycles(2);
    read_check("run1_busy_e5", R_STATUS, 32'h1);        // edge E0+5
    read_check("run1_done", R_STATUS, 32'h2);           // edge E0+7
    read_check("run1_acc0", R_ACC + 0,  32'd12);
    read_check("run1_acc1", R_ACC + 4,  32'hFFFFFFF6);
    read_check("run1_acc2", R_ACC + 8,  32'hFFFFFD44);
    read_check("run1_acc3", R_ACC + 12, 32'h40000000);

    // ---------------- run 2: START only, busy lockout, set-wins ----------------
    wb_write(R_STATUS, 32'h2);
    read_check("done_w1c", R_STATUS, 32'h0);
    wb_write(R_CTRL, 32'h1);                  // E0
    wb_write(R_A, 32'd9);                     // E0+2, ignored while busy
    wait_cycles(2);
    wb_write(R_STATUS, 32'h2);                // E0+5, same edge DONE is set
    read_check("run2_status", R_STATUS, 32'h6);
    read_check("run2_a0_kept", R_A, 32'd3);
    read_check("run2_acc0", R_ACC + 0,  32'd24);
    read_check("run2_acc1", R_ACC + 4,  32'hFFFFFFEC);
    read_check("run2_acc2", R_ACC + 8,  32'hFFFFFA88);
`ifdef WB_MAC_ARRAY_SATURATE_EN
    read_check("run2_acc3", R_ACC + 12, 32'h7FFFFFFF);
`else
    read_check("run2_acc3", R_ACC + 12, 32'h80000000);
`endif

    // ---------------- run 3: IE, START while busy, exact busy length ----------------
    wb_write(R_STATUS, 32'h6);
    read_check("run3_status0", R_STATUS, 32'h0);
    wb_write(R_CTRL, 32'h4);
    read_check("ie_readback", R_CTRL, 32'h4);
    check("irq_no_done", {31'b0, irq}, 32'd0);
    wb_write(R_CTRL, 32'h7);                  // E0
    wb_write(R_CTRL, 32'h5);                  // E0+2, START ignored
    wait_cycles(3);
    read_check("run3_idle_e6", R_STATUS, 32'h2);        // edge E0+6
    check("irq_set", {31'b0, irq}, 32'd1);
    read_check("run3_acc0", R_ACC + 0,  32'd12);
    read_check("run3_acc3", R_ACC + 12, 32'h40000000);
    wb_write(R_STATUS, 32'h2);
    check("irq_clear", {31'b0, irq}, 32'd0);

    // ---------------- run 4: reset at idx=2 ----------------
    wb_write(R_CTRL, 32'h1);                  // E0
    wait_cycles(2);                           // inside the idx=2 cycle
    rst_n = 1'b0;
    #2;
    check("midrst_ack", {31'b0, ack}, 32'd0);
    check("midrst_irq", {31'b0, irq}, 32'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    read_check("midrst_status", R_STATUS, 32'h0);
    read_check("midrst_ctrl", R_CTRL, 32'h0);
    for (int i = 0; i < 4; i++)
      read_check($sformatf("midrst_acc%0d", i), R_ACC + 32'(4 * i), 32'h0);
    read_check("midrst_a3", R_A + 12, 32'h0);

    wb_write(R_A + 0,  32'd7);
    wb_write(R_A + 4,  32'hFFFFFFFF);
    wb_write(R_A + 8,  32'd0);
    wb_write(R_A + 12, 32'd32767);
    wb_write(R_B + 0,  32'hFFFFFFFD);
    wb_write(R_B + 4,  32'hFFFFFFFF);
    wb_write(R_B + 8,  32'd5);
    wb_write(R_B + 12, 32'd32767);
    wb_write(R_CTRL, 32'h1);
    r = '0;
    for (k = 0; k < 20; k++) begin
      wb_read(R_STATUS, r);
      if (r[1]) break;
    end
    check("run4_status", r, 32'h2);
    read_check("run4_acc0", R_ACC + 0,  32'hFFFFFFEB);
    read_check("run4_acc1", R_ACC + 4,  32'd1);
    read_check("run4_acc2", R_ACC + 8,  32'd0);
    read_check("run4_acc3", R_ACC + 12, 32'h3FFF0001);

    // ---------------- CLEAR alone keeps DONE ----------------
    wb_write(R_CTRL, 32'h2);
    read_check("clear_acc3", R_ACC + 12, 32'h0);
    read_check("clear_acc0", R_ACC + 0,  32'h0);
    read_check("clear_status", R_STATUS, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
